aes_key_sched_seq: RTL and testbench

Iterative AES-256 key schedule that sits directly upstream of `AESDecrypt`. It expands a 256-bit cipher key into the 15 round keys over 13 clock cycles, reusing one word-transform datapath. It holds the full round-key file stable for the decryptor's `key` input and flags when the file is valid. It replaces the fully unrolled combinational `ExpandKey` where area matters more than key-change latency.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_key_sched_seq.sv | 86 ++++++++
 tb/tb_aes_key_sched_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-256 key-schedule constants, types and word-transform helpers
package aes_pkg;

    localparam int NUM_ROUNDS = 14;
    localparam int NUM_RKEYS  = NUM_ROUNDS + 1;

    typedef logic [127:0] rkey_t;

    // Round constants indexed by k/2 (1..7); entry 0 is never used.
    localparam logic [7:0][7:0] RCON = {
        8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
    };

    // FSM encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_EXPAND = 1'b1;

    // Even entries rotate the word before SubWord; odd entries use it as-is.
    function automatic logic [31:0] rot_sel(input logic [31:0] w, input logic even);
        return even ? {w[23:0], w[31:24]} : w;
    endfunction

    // Even entries fold the round constant into the top byte after SubWord.
    function automatic logic [31:0] rcon_mix(input logic [31:0] s, input logic [3:0] k);
        return k[0] ? s : (s ^ {RCON[k[3:1]], 24'h0});
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte in, one byte out
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup
    always_comb begin
        dout = SBOX[din];
    end

endmodule

// File: rtl/aes_key_sched_seq.sv
// rtl/aes_key_sched_seq.sv - iterative AES-256 key expansion, one round key per cycle
module aes_key_sched_seq
    import aes_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [255:0]                key_in,
    output rkey_t [NUM_RKEYS-1:0]       key_out,
    output logic                        busy,
    output logic                        key_valid
);

    state_t      state;
    logic [3:0]  k;
    logic [3:0]  k_m1;
    logic [3:0]  k_m2;
    rkey_t       p;
    rkey_t       q;
    logic [31:0] t_pre;
    logic [31:0] t_sub;
    logic [31:0] t;
    logic [31:0] w0, w1, w2, w3;

    // Previous two entries feed the word transform and the xor chain.
    always_comb begin
        k_m1  = k - 4'd1;
        k_m2  = k - 4'd2;
        p     = key_out[k_m1];
        q     = key_out[k_m2];
        t_pre = rot_sel(p[31:0], ~k[0]);
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_subword
            aes_sbox u_sbox (
                .din  (t_pre[g*8 +: 8]),
                .dout (t_sub[g*8 +: 8])
            );
        end
    endgenerate

    // Rcon fold and the 4-deep xor chain producing the next round key.
    always_comb begin
        t  = rcon_mix(t_sub, k);
        w0 = q[127:96] ^ t;
        w1 = q[95:64]  ^ w0;
        w2 = q[63:32]  ^ w1;
        w3 = q[31:0]   ^ w2;
    end

    // Control FSM and round-key file; start is only honoured in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_out   <= '0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            state     <= ST_IDLE;
            k         <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_out[0] <= key_in[255:128];
                        key_out[1] <= key_in[127:0];
                        k          <= 4'd2;
                        key_valid  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_EXPAND;
                    end
                end
                default: begin
                    key_out[k] <= {w0, w1, w2, w3};
                    k          <= k + 4'd1;
                    if (k == 4'(NUM_ROUNDS)) begin
                        busy      <= 1'b0;
                        key_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// tb/tb_aes_key_sched_seq.sv - directed self-checking bench for aes_key_sched_seq
module tb_aes_key_sched_seq;

    logic                clk;
    logic                rst;
    logic                start;
    logic [255:0]        key_in;
    logic [14:0][127:0]  key_out;
    logic                busy;
    logic                key_valid;

    int total;
    int bad;

    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] A3_RK3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] C3_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    aes_key_sched_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .key_out   (key_out),
        .busy      (busy),
        .key_valid (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start across exactly one rising edge (E0).
    task automatic pulse_start(input logic [255:0] key);
        start  = 1'b1;
        key_in = key;
        tick();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        rst = 1'b1;
        #1;
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", key_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (key_out !== '0) begin bad++; $display("FAIL reset_file got=%h want=0", key_out[14]); end
        tick();
        rst = 1'b0;
        repeat (5) tick();
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", key_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
        total++; if (key_out !== '0) begin bad++; $display("FAIL idle_file got=%h want=0", key_out[14]); end
    endtask

    task automatic test_fips_a3();
        int first_valid;
        first_valid = -1;
        pulse_start(KEY_A3);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL a3_busy_e0 got=%b want=1", busy); end
        total++; if (key_out[0] !== KEY_A3[255:128]) begin bad++; $display("FAIL a3_rk0 got=%h want=%h", key_out[0], KEY_A3[255:128]); end
        total++; if (key_out[1] !== KEY_A3[127:0]) begin bad++; $display("FAIL a3_rk1 got=%h want=%h", key_out[1], KEY_A3[127:0]); end
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (key_valid === 1'b1 && first_valid < 0) first_valid = n;
            if (n == 12) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL a3_busy_e12 got=%b want=1", busy); end
            end
            if (n == 13) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL a3_busy_e13 got=%b want=0", busy); end
            end
        end
        total++; if (first_valid != 13) begin bad++; $display("FAIL a3_latency got=%0d want=13", first_valid); end
        total++; if (key_out[2] !== A3_RK2) begin bad++; $display("FAIL a3_rk2 got=%h want=%h", key_out[2], A3_RK2); end
        total++; if (key_out[3] !== A3_RK3) begin bad++; $display("FAIL a3_rk3 got=%h want=%h", key_out[3], A3_RK3); end
        total++; if (key_out[14] !== A3_RK14) begin bad++; $display("FAIL a3_rk14 got=%h want=%h", key_out[14], A3_RK14); end
    endtask

    // Restart while valid; key_in is scrambled after acceptance to show it is not resampled.
    task automatic test_fips_c3();
        pulse_start(KEY_C3);
        key_in = ~KEY_C3;
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL c3_valid_drop got=%b want=0", key_valid); end
        total++; if (key_out[0] !== KEY_C3[255:128]) begin bad++; $display("FAIL c3_rk0 got=%h want=%h", key_out[0], KEY_C3[255:128]); end
        repeat (13) tick();
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL c3_valid got=%b want=1", key_valid); end
        total++; if (key_out[14] !== C3_RK14) begin bad++; $display("FAIL c3_rk14 got=%h want=%h", key_out[14], C3_RK14); end
    endtask

    task automatic test_ignore_start();
        pulse_start(KEY_A3);
        for (int n = 1; n <= 13; n++) begin
            start  = (n == 3 || n == 13);
            key_in = KEY_C3;
            tick();
            start  = 1'b0;
        end
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL ign_valid got=%b want=1", key_valid); end
        total++; if (key_out[0] !== KEY_A3[255:128]) begin bad++; $display("FAIL ign_rk0 got=%h want=%h", key_out[0], KEY_A3[255:128]); end
        total++; if (key_out[14] !== A3_RK14) begin bad++; $display("FAIL ign_rk14 got=%h want=%h", key_out[14], A3_RK14); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int early;
        early = 0;
        pulse_start(KEY_A3);
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || key_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got=%b%b want=00", busy, key_valid); end
        total++; if (key_out !== '0) begin bad++; $display("FAIL mid_rst_file got=%h want=0", key_out[0]); end
        tick();
        rst = 1'b0;
        tick();
        pulse_start(KEY_C3);
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (key_valid !== 1'b0) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL mid_early_valid got=%0d want=0", early); end
        tick();
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%b want=1", key_valid); end
        total++; if (key_out[14] !== C3_RK14) begin bad++; $display("FAIL mid_rk14 got=%h want=%h", key_out[14], C3_RK14); end
        total++; if (key_out[1] !== KEY_C3[127:0]) begin bad++; $display("FAIL mid_rk1 got=%h want=%h", key_out[1], KEY_C3[127:0]); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        start  = 1'b0;
        key_in = '0;
        test_reset();
        test_fips_a3();
        test_fips_c3();
        test_ignore_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
